// File: rtl/pq_pkg.sv
// Shared types for the HWPQ interface: key/value item, empty marker and the
// sorter state type. PQ_SORTER_DESCEND_EN selects the descending key mapping
// used by pq_stream_sorter.
package pq_pkg;

  localparam int unsigned KEY_WIDTH   = 16;
  localparam int unsigned VAL_WIDTH   = 16;
  localparam int unsigned PQ_CAPACITY = 4;

  localparam logic [KEY_WIDTH-1:0] KEYINF = '1;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  localparam kv_t KV_EMPTY = '{key: KEYINF, val: '0};

  typedef enum logic [0:0] {SRT_LOAD, SRT_DRAIN} srt_state_t;

  // Key mapping between the stream domain and the queue domain. It is its
  // own inverse, so the same function is used in both directions.
  function automatic kv_t kv_map(input kv_t kv);
`ifdef PQ_SORTER_DESCEND_EN
    return '{key: ~kv.key, val: kv.val};
`else
    return kv;
`endif
  endfunction

endpackage

// File: rtl/pq_stream_sorter.sv
// Client of an HWPQ: loads a batch from the input stream into the queue, then
// drains it to the output stream in key order. A batch larger than CAP is
// split into CAP-sized chunks and flags overflow.
// Macro PQ_SORTER_DESCEND_EN: emit keys in descending order.
module pq_stream_sorter
  import pq_pkg::*;
#(
  parameter int unsigned CAP = PQ_CAPACITY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  kv_t  in_kv,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output kv_t  out_kv,
  output logic out_last,
  output logic overflow,
  output logic pq_enq,
  output kv_t  pq_kvi,
  output logic pq_deq,
  input  kv_t  pq_kvo,
  input  logic pq_busy,
  input  logic pq_full,
  input  logic pq_empty
);

  localparam int unsigned CW = $clog2(CAP + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  srt_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  kv_t           out_kv_q, out_kv_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          overflow_q, overflow_d;
  logic          alive_q;
  logic          accept;
  logic          reload;

  // Handshake and queue command strobes; alive_q holds in_ready low in reset.
  always_comb begin
    in_ready = alive_q & (state_q == SRT_LOAD) & ~pq_busy & ~pq_full;
    accept   = in_valid & in_ready;
    reload   = (state_q == SRT_DRAIN) & (~out_valid_q | out_ready) &
               ~pq_empty & ~pq_busy & (count_q != '0);
    pq_enq   = accept;
    pq_kvi   = accept ? kv_map(in_kv) : KV_EMPTY;
    pq_deq   = reload;
  end

  // Next-state: count items in during LOAD, stream them out during DRAIN.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_kv_d    = out_kv_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;
    case (state_q)
      SRT_LOAD: begin
        if (accept) begin
          count_d = count_q + CNT_ONE;
          if (in_last) state_d = SRT_DRAIN;
        end else if (pq_full && count_q != '0) begin
          // queue filled before in_last: drain this chunk, rest follows later
          overflow_d = 1'b1;
          state_d    = SRT_DRAIN;
        end
      end
      SRT_DRAIN: begin
        if (reload) begin
          out_kv_d    = kv_map(pq_kvo);
          out_valid_d = 1'b1;
          out_last_d  = (count_q == CNT_ONE);
          count_d     = count_q - CNT_ONE;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) state_d = SRT_LOAD;
        end
      end
      default: state_d = SRT_LOAD;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SRT_LOAD;
      count_q     <= '0;
      out_kv_q    <= KV_EMPTY;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_kv_q    <= out_kv_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
      alive_q     <= 1'b1;
    end
  end

  assign out_kv    = out_kv_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pq_stream_sorter.sv
// Bench for pq_stream_sorter against a behavioural min-queue. Expected output
// is computed per batch (chunks of CAP, each sorted) and checked by a monitor.
// Honours PQ_SORTER_DESCEND_EN for the expected order.
`timescale 1ns/1ps
module tb_pq_stream_sorter;
  import pq_pkg::*;

  localparam int unsigned CAP = PQ_CAPACITY;

  typedef struct packed {
    kv_t  kv;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic pq_busy = 1'b0;
  kv_t  in_kv = KV_EMPTY;
  logic in_ready, out_valid, out_last, overflow, pq_enq, pq_deq;
  kv_t  out_kv, pq_kvi;
  kv_t  pq_kvo = KV_EMPTY;
  logic pq_full = 1'b0;
  logic pq_empty = 1'b1;

  always #5 clk = ~clk;

  pq_stream_sorter #(.CAP(CAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_kv(in_kv), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_kv(out_kv), .out_last(out_last),
    .overflow(overflow),
    .pq_enq(pq_enq), .pq_kvi(pq_kvi), .pq_deq(pq_deq), .pq_kvo(pq_kvo),
    .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // ---------------- behavioural priority queue ----------------
  kv_t qm[$];

  function automatic int unsigned min_idx();
    int unsigned m = 0;
    for (int unsigned i = 1; i < qm.size(); i++)
      if (qm[i].key < qm[m].key) m = i;
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) qm.delete();
    else begin
      if (pq_deq && qm.size() != 0) qm.delete(min_idx());
      if (pq_enq) qm.push_back(pq_kvi);
    end
    pq_kvo   <= (qm.size() == 0) ? KV_EMPTY : qm[min_idx()];
    pq_empty <= (qm.size() == 0);
    pq_full  <= (qm.size() >= CAP);
  end

  // ---------------- environment: busy and out_ready ----------------
  int unsigned busy_cycles = 0;
  bit          busy_rand = 1'b0;
  int unsigned ready_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
  logic [3:0]  ready_pat = 4'b1001;
  logic [1:0]  pat_i = '0;

  always @(negedge clk) begin
    if (busy_cycles != 0) begin
      pq_busy = 1'b1;
      busy_cycles--;
    end else begin
      pq_busy = busy_rand && ($urandom_range(0, 3) == 0);
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1: begin out_ready = ready_pat[pat_i]; pat_i = pat_i + 2'd1; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboard and monitor ----------------
  exp_t sb[$];
  bit   exp_ovf = 1'b0;
  bit   prev_stall = 1'b0;
  kv_t  prev_kv;
  logic prev_last;
  exp_t e;

  initial forever begin
    @(negedge clk); #1;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("one_cmd_per_cycle", 64'(pq_enq & pq_deq), 0);
      if (pq_deq) check("deq_when_empty", 64'(pq_empty), 0);
      if (pq_busy) begin
        check("busy_enq", 64'(pq_enq), 0);
        check("busy_deq", 64'(pq_deq), 0);
        check("busy_in_ready", 64'(in_ready), 0);
      end
      if (out_valid) check("drain_in_ready", 64'(in_ready), 0);
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 1);
        check("stall_kv", 64'(out_kv), 64'(prev_kv));
        check("stall_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(out_kv), 64'(KV_EMPTY));
        end else begin
          e = sb.pop_front();
          check("out_key", 64'(out_kv.key), 64'(e.kv.key));
          check("out_val", 64'(out_kv.val), 64'(e.kv.val));
          check("out_last", 64'(out_last), 64'(e.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_kv    = out_kv;
      prev_last  = out_last;
    end
  end

  // ---------------- reference model and stimulus ----------------
  function automatic bit goes_before(input kv_t a, input kv_t b);
`ifdef PQ_SORTER_DESCEND_EN
    return a.key > b.key;
`else
    return a.key < b.key;
`endif
  endfunction

  function automatic void expect_batch(input kv_t items[$]);
    kv_t ch[$];
    int unsigned p;
    for (int unsigned s = 0; s < items.size(); s += CAP) begin
      ch.delete();
      for (int unsigned i = s; i < items.size() && i < s + CAP; i++) begin
        p = 0;
        while (p < ch.size() && !goes_before(items[i], ch[p])) p++;
        ch.insert(p, items[i]);
      end
      for (int unsigned j = 0; j < ch.size(); j++)
        sb.push_back('{kv: ch[j], last: (j == ch.size() - 1)});
    end
    if (items.size() > CAP) exp_ovf = 1'b1;
  endfunction

  task automatic send_batch(input kv_t items[$], input int busy_at);
    int unsigned waited;
    expect_batch(items);
    for (int i = 0; i < items.size(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_kv    = items[i];
      in_last  = (i == items.size() - 1);
      #1;
      waited = 0;
      while (!in_ready && waited < 200) begin
        @(negedge clk); #1;
        waited++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", 64'(in_ready), 1);
        break;
      end
      if (i == busy_at) busy_cycles = 3;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_kv    = KV_EMPTY;
  endtask

  task automatic wait_drain();
    int unsigned waited = 0;
    while ((sb.size() != 0 || out_valid) && waited < 500) begin
      @(negedge clk); #2;
      waited++;
    end
    check("drain_complete", 64'(sb.size()), 0);
    check("overflow", 64'(overflow), 64'(exp_ovf));
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_kv", 64'(out_kv), 64'(KV_EMPTY));
    check("rst_out_last", 64'(out_last), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_pq_enq", 64'(pq_enq), 0);
    check("rst_pq_deq", 64'(pq_deq), 0);
    check("rst_pq_kvi", 64'(pq_kvi), 64'(KV_EMPTY));
  endtask

  function automatic kv_t mk(input int unsigned k, input int unsigned v);
    return '{key: KEY_WIDTH'(k), val: VAL_WIDTH'(v)};
  endfunction

  kv_t b[$];
  int unsigned n, k;
  bit dup;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // basic batch, always ready
    b = '{mk(5, 16'hA5), mk(1, 16'hA1), mk(9, 16'hA9), mk(3, 16'hA3)};
    send_batch(b, -1);
    wait_drain();

    // backpressure pattern during drain
    ready_mode = 1;
    b = '{mk(40, 16'h40), mk(10, 16'h10), mk(30, 16'h30), mk(20, 16'h20), mk(50, 16'h50)};
    send_batch(b, -1);
    wait_drain();
    ready_mode = 0;

    // busy held for 3 cycles mid-load
    b = '{mk(7, 1), mk(6, 2), mk(8, 3), mk(2, 4)};
    send_batch(b, 1);
    wait_drain();

    // oversize batch splits into chunks
    b = '{mk(60, 6), mk(11, 1), mk(33, 3), mk(22, 2), mk(55, 5), mk(44, 4)};
    send_batch(b, -1);
    wait_drain();

    // reset in the middle of a drain
    b = '{mk(90, 9), mk(70, 7), mk(80, 8), mk(75, 5)};
    send_batch(b, -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    sb.delete();
    exp_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b = '{mk(2, 16'h22), mk(2, 16'h22), mk(7, 16'h77)};
    send_batch(b, -1);
    wait_drain();

    // order direction
    b = '{mk(4, 16'h44), mk(8, 16'h88), mk(1, 16'h11)};
    send_batch(b, -1);
    wait_drain();

    // randomized batches with random backpressure and busy
    ready_mode = 2;
    busy_rand  = 1'b1;
    for (int t = 0; t < 20; t++) begin
      b.delete();
      n = $urandom_range(1, 2 * CAP + 2);
      while (b.size() < n) begin
        k = $urandom_range(1, 1000);
        dup = 1'b0;
        foreach (b[j]) if (b[j].key == KEY_WIDTH'(k)) dup = 1'b1;
        if (!dup) b.push_back(mk(k, $urandom));
      end
      send_batch(b, -1);
      wait_drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
